// File: rtl/stopwatch_timebase.sv
// Stopwatch timebase: four free-running clock dividers plus two pushbutton debouncers.
// Define STOPWATCH_BTN_PULSE_EN to add one-cycle press strobes on the debounced buttons.

module sw_divider #(
  parameter int D = 10,
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  output logic [W-1:0] o_cnt,
  output logic         o_tick,
  output logic         o_sq
);
  localparam logic [W-1:0] LP_LAST = W'(D - 1);
  localparam logic [W-1:0] LP_HALF = W'(D / 2);

  logic [W-1:0] r_cnt;
  logic         r_sq;
  logic [W-1:0] w_cnt_next;
  logic         w_wrap;

  always_comb begin
    w_wrap     = (r_cnt == LP_LAST);
    w_cnt_next = w_wrap ? '0 : r_cnt + W'(1);
  end

  // Square wave is derived from the next count so it changes on the same edge as the counter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
      r_sq  <= 1'b0;
    end else begin
      r_cnt <= w_cnt_next;
      r_sq  <= (w_cnt_next >= LP_HALF);
    end
  end

  assign o_cnt  = r_cnt;
  assign o_tick = w_wrap;
  assign o_sq   = r_sq;
endmodule

module sw_debounce #(
  parameter int DB_CYCLES = 8
) (
  input  logic i_clk,
  input  logic i_rst,
`ifdef STOPWATCH_BTN_PULSE_EN
  output logic o_press,
`endif
  input  logic i_raw,
  output logic o_level
);
  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] LP_LAST = CW'(DB_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_stable;
  logic [CW-1:0] r_cnt;
  logic          w_accept;

  assign w_accept = (r_sync2 != r_stable) && (r_cnt == LP_LAST);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_level = r_stable;

`ifdef STOPWATCH_BTN_PULSE_EN
  logic r_press;

  // Registered alongside r_stable so the strobe lines up with the rising level.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_press <= 1'b0;
    else       r_press <= w_accept & r_sync2;
  end

  assign o_press = r_press;
`endif
endmodule

module stopwatch_timebase #(
  parameter int DIV_1HZ   = 100000000,
  parameter int DIV_2HZ   = 50000000,
  parameter int DIV_7SEG  = 262144,
  parameter int DIV_ADJ   = 20000000,
  parameter int DB_CYCLES = 1000000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_btn_right,
  input  logic        i_btn_center,
  output logic [26:0] o_cnt_1hz,
  output logic [25:0] o_cnt_2hz,
  output logic [17:0] o_cnt_7seg,
  output logic [25:0] o_cnt_adj,
  output logic        o_tick_1hz,
  output logic        o_tick_2hz,
  output logic        o_tick_7seg,
  output logic        o_tick_adj,
  output logic        o_clk_1hz,
  output logic        o_clk_2hz,
  output logic        o_clk_7seg,
  output logic        o_clk_adj,
`ifdef STOPWATCH_BTN_PULSE_EN
  output logic        o_btn_reset_press,
  output logic        o_btn_set_pause_press,
`endif
  output logic        o_btn_reset,
  output logic        o_btn_set_pause
);
  sw_divider #(.D(DIV_1HZ), .W(27)) u_div_1hz (
    .i_clk(i_clk), .i_rst(i_rst), .o_cnt(o_cnt_1hz), .o_tick(o_tick_1hz), .o_sq(o_clk_1hz)
  );

  sw_divider #(.D(DIV_2HZ), .W(26)) u_div_2hz (
    .i_clk(i_clk), .i_rst(i_rst), .o_cnt(o_cnt_2hz), .o_tick(o_tick_2hz), .o_sq(o_clk_2hz)
  );

  sw_divider #(.D(DIV_7SEG), .W(18)) u_div_7seg (
    .i_clk(i_clk), .i_rst(i_rst), .o_cnt(o_cnt_7seg), .o_tick(o_tick_7seg), .o_sq(o_clk_7seg)
  );

  sw_divider #(.D(DIV_ADJ), .W(26)) u_div_adj (
    .i_clk(i_clk), .i_rst(i_rst), .o_cnt(o_cnt_adj), .o_tick(o_tick_adj), .o_sq(o_clk_adj)
  );

  sw_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_right (
    .i_clk(i_clk),
    .i_rst(i_rst),
`ifdef STOPWATCH_BTN_PULSE_EN
    .o_press(o_btn_reset_press),
`endif
    .i_raw(i_btn_right),
    .o_level(o_btn_reset)
  );

  sw_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_center (
    .i_clk(i_clk),
    .i_rst(i_rst),
`ifdef STOPWATCH_BTN_PULSE_EN
    .o_press(o_btn_set_pause_press),
`endif
    .i_raw(i_btn_center),
    .o_level(o_btn_set_pause)
  );
endmodule

// File: tb/tb_stopwatch_timebase.sv
// Directed bench for stopwatch_timebase with small divisors; edge k counts posedges since reset release.
module tb_stopwatch_timebase;
  logic        clk = 1'b0;
  logic        rst;
  logic        btn_right;
  logic        btn_center;
  logic [26:0] cnt_1hz;
  logic [25:0] cnt_2hz;
  logic [17:0] cnt_7seg;
  logic [25:0] cnt_adj;
  logic        tick_1hz, tick_2hz, tick_7seg, tick_adj;
  logic        clk_1hz, clk_2hz, clk_7seg, clk_adj;
  logic        btn_reset, btn_set_pause;
`ifdef STOPWATCH_BTN_PULSE_EN
  logic        btn_reset_press, btn_set_pause_press;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stopwatch_timebase #(
    .DIV_1HZ(10), .DIV_2HZ(6), .DIV_7SEG(4), .DIV_ADJ(5), .DB_CYCLES(8)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_btn_right(btn_right),
    .i_btn_center(btn_center),
    .o_cnt_1hz(cnt_1hz),
    .o_cnt_2hz(cnt_2hz),
    .o_cnt_7seg(cnt_7seg),
    .o_cnt_adj(cnt_adj),
    .o_tick_1hz(tick_1hz),
    .o_tick_2hz(tick_2hz),
    .o_tick_7seg(tick_7seg),
    .o_tick_adj(tick_adj),
    .o_clk_1hz(clk_1hz),
    .o_clk_2hz(clk_2hz),
    .o_clk_7seg(clk_7seg),
    .o_clk_adj(clk_adj),
`ifdef STOPWATCH_BTN_PULSE_EN
    .o_btn_reset_press(btn_reset_press),
    .o_btn_set_pause_press(btn_set_pause_press),
`endif
    .o_btn_reset(btn_reset),
    .o_btn_set_pause(btn_set_pause)
  );

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at step %0d: observed %0d expected %0d", tag, k, obs, exp);
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cnt_1hz"}, 0, 32'(cnt_1hz), 0);
    chk({tag, "_cnt_2hz"}, 0, 32'(cnt_2hz), 0);
    chk({tag, "_cnt_7seg"}, 0, 32'(cnt_7seg), 0);
    chk({tag, "_cnt_adj"}, 0, 32'(cnt_adj), 0);
    chk({tag, "_ticks"}, 0, 32'({tick_1hz, tick_2hz, tick_7seg, tick_adj}), 0);
    chk({tag, "_sqwaves"}, 0, 32'({clk_1hz, clk_2hz, clk_7seg, clk_adj}), 0);
    chk({tag, "_btns"}, 0, 32'({btn_reset, btn_set_pause}), 0);
  endtask

  initial begin
    rst        = 1'b1;
    btn_right  = 1'b0;
    btn_center = 1'b0;
    edge_step();
    edge_step();
    chk_all_zero("in_reset");

    // Release reset; center button held from the very first edge.
    rst        = 1'b0;
    btn_center = 1'b1;
    chk("cnt_1hz_k0", 0, 32'(cnt_1hz), 0);

    for (int k = 1; k <= 63; k++) begin
      edge_step();
      chk("cnt_1hz", k, 32'(cnt_1hz), 32'(k % 10));
      chk("tick_1hz", k, 32'(tick_1hz), 32'(k % 10 == 9));
      chk("clk_1hz", k, 32'(clk_1hz), 32'(k % 10 >= 5));
      chk("cnt_2hz", k, 32'(cnt_2hz), 32'(k % 6));
      chk("tick_2hz", k, 32'(tick_2hz), 32'(k % 6 == 5));
      chk("clk_2hz", k, 32'(clk_2hz), 32'(k % 6 >= 3));
      chk("cnt_7seg", k, 32'(cnt_7seg), 32'(k % 4));
      chk("tick_7seg", k, 32'(tick_7seg), 32'(k % 4 == 3));
      chk("clk_7seg", k, 32'(clk_7seg), 32'(k % 4 >= 2));
      chk("cnt_adj", k, 32'(cnt_adj), 32'(k % 5));
      chk("tick_adj", k, 32'(tick_adj), 32'(k % 5 == 4));
      chk("clk_adj", k, 32'(clk_adj), 32'(k % 5 >= 2));
      // Center sampled high on edges 1..30: rises at edge 10, falls 10 edges after release at 40.
      chk("btn_set_pause", k, 32'(btn_set_pause), 32'(k >= 10 && k < 40));
      // Right bounces (edges 41-45 high, 46-47 low) then steady from edge 48: rises at edge 57.
      chk("btn_reset", k, 32'(btn_reset), 32'(k >= 57));
`ifdef STOPWATCH_BTN_PULSE_EN
      chk("set_pause_press", k, 32'(btn_set_pause_press), 32'(k == 10));
      chk("reset_press", k, 32'(btn_reset_press), 32'(k == 57));
`endif
      btn_center = (k + 1 <= 30);
      btn_right  = ((k + 1 >= 41) && (k + 1 <= 45)) || (k + 1 >= 48);
    end

    // At edge 63 cnt_2hz is 3 and btn_reset is 1; assert reset between edges.
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
`ifdef STOPWATCH_BTN_PULSE_EN
    chk("async_rst_press", 0, 32'({btn_reset_press, btn_set_pause_press}), 0);
`endif
    edge_step();
    chk_all_zero("rst_held");
    rst = 1'b0;
    chk("restart_cnt_2hz", 0, 32'(cnt_2hz), 0);
    for (int j = 1; j <= 12; j++) begin
      edge_step();
      chk("restart_cnt_2hz", j, 32'(cnt_2hz), 32'(j % 6));
      chk("restart_cnt_1hz", j, 32'(cnt_1hz), 32'(j % 10));
      // Right button still held through reset: reported at edge 10 after release.
      chk("restart_btn_reset", j, 32'(btn_reset), 32'(j >= 10));
      chk("restart_btn_set_pause", j, 32'(btn_set_pause), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/stopwatch_timebase.md
Name: stopwatch_timebase

Overview:
- Timebase and button-conditioning front end for the stopwatch.
- Divides the board clock (100 MHz nominal) into four free-running rates: 1 Hz count, 2 Hz blink, ~380 Hz display multiplex, 5 Hz adjust.
- Each rate is exposed as counter value, one-cycle tick and 50% square wave.
- Debounces the two control pushbuttons (right = reset, center = set/pause) into clean levels.

Parameters:
- DIV_1HZ, 100000000, clk cycles per 1 Hz period; fits 27 bits
- DIV_2HZ, 50000000, cycles per 2 Hz period; fits 26 bits
- DIV_7SEG, 262144, cycles per display-scan period (~381 Hz); fits 18 bits
- DIV_ADJ, 20000000, cycles per 5 Hz period; fits 26 bits
- DB_CYCLES, 1000000, consecutive cycles a new button level must persist (10 ms)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- btn_right  in  1  raw reset pushbutton, asynchronous to clk
- btn_center  in  1  raw set/pause pushbutton, asynchronous to clk
- cnt_1hz  out  27  1 Hz divider count
- cnt_2hz  out  26  2 Hz divider count
- cnt_7seg  out  18  display divider count
- cnt_adj  out  26  5 Hz divider count
- tick_1hz, tick_2hz, tick_7seg, tick_adj  out  1 each  one-cycle strobes
- clk_1hz, clk_2hz, clk_7seg, clk_adj  out  1 each  registered square waves
- btn_reset  out  1  debounced btn_right level
- btn_set_pause  out  1  debounced btn_center level

Behaviour:
- Single clock domain on clk. Reset is asynchronous and active-high.
- Reset forces to 0: all counters, square waves, debounce counters, synchronizers and debounced outputs. Ticks therefore read 0 during reset.
- Divider counters, same rule for each divider with divisor D:
  - Counter steps 0..D-1 by +1 per clk edge, then wraps to 0. No enable; free-running.
  - tick is combinational, high exactly when count == D-1: one cycle per D cycles, first at cycle D-1 after reset release.
  - Square wave is registered, high when count >= D/2 (integer division). Period D; duty exactly 50% for even D.
  - Square wave edges coincide with the counter update, so it is glitch-free and may drive a clock pin.
- Each counter is zero-extended to its port width.
- Debounce, two identical instances:
  - Raw input passes through a 2-flop synchronizer.
  - A stable register holds the output. Counter clears whenever the synced level equals stable, and increments on each cycle it differs.
  - When the counter is at DB_CYCLES-1 and the level still differs, stable takes the new level and the counter clears.
  - Output changes DB_CYCLES+2 edges after the first edge that samples the new raw level.
  - Any bounce back to the stable level before then restarts the count from 0.
  - Press and release are filtered symmetrically.
- Reset mid-operation returns everything to 0 immediately. Counting resumes from 0 on the first edge after rst falls.
- A button held through reset is reported DB_CYCLES+2 cycles after release of rst.

Optional Feature:
- Macro: STOPWATCH_BTN_PULSE_EN
- Defined: adds outputs btn_reset_press and btn_set_pause_press, each 1 bit.
  - Each is high for exactly one cycle on the edge where the corresponding debounced level goes 0->1 (registered, reset to 0).
  - No pulse on release.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Bench parameters: DIV_1HZ=10, DIV_2HZ=6, DIV_7SEG=4, DIV_ADJ=5, DB_CYCLES=8.
- Reset then run 30 cycles -> cnt_1hz 0..9 repeating; tick_1hz high at cycles 9, 19, 29 only; clk_1hz low for counts 0-4, high for 5-9.
- Odd divisor -> cnt_adj wraps 4->0; clk_adj high for counts 2-4; tick_adj every 5 cycles.
- btn_center held 1 from cycle 0 -> btn_set_pause rises exactly at edge 10, never earlier; release gives a fall 10 edges later.
- btn_right bounce 1 for 5 cycles, 0 for 2, then steady 1 -> btn_reset stays 0 through the bounce and rises 10 edges after the final rising sample.
- Assert rst asynchronously mid-count (cnt_2hz=3, btn_reset=1) -> all outputs 0 without a clock edge; after release, cnt_2hz restarts 0,1,2.
- With STOPWATCH_BTN_PULSE_EN -> btn_set_pause_press high for exactly one cycle, coincident with the btn_set_pause rising edge; 0 on release.
